// File: rtl/ltc2308_responder.sv
// Device-side model of the LTC2308 serial ADC: conversion delay, 6-bit config shift-in
// and 12-bit result shift-out, driven from a parallel bus of channel codes.
module ltc2308_responder #(
   parameter int unsigned CONV_CYCLES = 80,
   parameter int unsigned DATA_W      = 12,
   parameter logic [5:0]  DEFAULT_CFG = 6'b100010
) (
   input  logic                  clk_clk,
   input  logic                  reset_reset,
   input  logic                  adc_convst,
   input  logic                  adc_sck,
   input  logic                  adc_sdi,
   output logic                  adc_sdo,
   input  logic [8*DATA_W-1:0]   chan_values,
   output logic [5:0]            cfg_word,
   output logic                  cfg_update,
   output logic                  busy,
   output logic                  protocol_err,
   input  logic                  err_clear
);

   localparam int unsigned CntW = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;

   typedef enum logic [1:0] {StIdle, StConvert, StShift} state_e;

   state_e              state_q, state_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic [5:1]          act_cfg_q, act_cfg_d;
   logic [5:0]          pend_cfg_q, pend_cfg_d;
   logic [5:0]          shreg_q, shreg_d;
   logic [2:0]          rise_cnt_q, rise_cnt_d;
   logic [DATA_W-1:0]   result_q, result_d;
   logic                sdo_q, sdo_d;
   logic                cfg_update_q, cfg_update_d;
   logic                err_q, err_d;
   logic                err_event;

   // [0],[1] form the synchroniser; [2] is the delayed copy used for edge detection.
   logic [2:0]          convst_sync_q, sck_sync_q;
   logic [1:0]          sdi_sync_q;
   logic                convst_rise, sck_rise, sck_fall, sdi_bit;

   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         convst_sync_q <= '0;
         sck_sync_q    <= '0;
         sdi_sync_q    <= '0;
      end else begin
         convst_sync_q <= {convst_sync_q[1:0], adc_convst};
         sck_sync_q    <= {sck_sync_q[1:0], adc_sck};
         sdi_sync_q    <= {sdi_sync_q[0], adc_sdi};
      end
   end

   assign convst_rise = convst_sync_q[1] & ~convst_sync_q[2];
   assign sck_rise    = sck_sync_q[1] & ~sck_sync_q[2];
   assign sck_fall    = ~sck_sync_q[1] & sck_sync_q[2];
   assign sdi_bit     = sdi_sync_q[1];

   // Result computation from the active config {S/D, O/S, S1, S0, UNI}.
   logic [DATA_W-1:0]   ch [8];
   logic [DATA_W-1:0]   pos_val, neg_val, code;
   logic [DATA_W:0]     diff;

   always_comb begin
      for (int i = 0; i < 8; i++) begin
         ch[i] = chan_values[i*DATA_W +: DATA_W];
      end
      pos_val = ch[{act_cfg_q[3:2], act_cfg_q[4]}];
      neg_val = ch[{act_cfg_q[3:2], ~act_cfg_q[4]}];
      diff    = {1'b0, pos_val} - {1'b0, neg_val};
      if (act_cfg_q[5]) begin
         code = act_cfg_q[1] ? pos_val : (pos_val ^ {1'b1, {(DATA_W-1){1'b0}}});
      end else if (act_cfg_q[1]) begin
         code = diff[DATA_W] ? '0 : diff[DATA_W-1:0];
      end else begin
         code = diff[DATA_W:1];
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      act_cfg_d    = act_cfg_q;
      pend_cfg_d   = pend_cfg_q;
      shreg_d      = shreg_q;
      rise_cnt_d   = rise_cnt_q;
      result_d     = result_q;
      sdo_d        = sdo_q;
      cfg_update_d = 1'b0;
      err_event    = 1'b0;

      unique case (state_q)
         StIdle: begin
            sdo_d = 1'b0;
            if (convst_rise) begin
               act_cfg_d  = pend_cfg_q[5:1];
               cnt_d      = '0;
               rise_cnt_d = '0;
               state_d    = StConvert;
            end
         end
         StConvert: begin
            err_event = sck_rise | sck_fall | convst_rise;
            if (cnt_q == CntW'(CONV_CYCLES - 1)) begin
               result_d   = code;
               sdo_d      = code[DATA_W-1];
               rise_cnt_d = '0;
               state_d    = StShift;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StShift: begin
            if (convst_rise) begin
               // Frame ends early or on time; a short frame leaves the config untouched.
               act_cfg_d  = pend_cfg_q[5:1];
               cnt_d      = '0;
               rise_cnt_d = '0;
               sdo_d      = 1'b0;
               state_d    = StConvert;
            end else begin
               if (sck_rise && rise_cnt_q != 3'd6) begin
                  shreg_d    = {shreg_q[4:0], sdi_bit};
                  rise_cnt_d = rise_cnt_q + 3'd1;
                  if (rise_cnt_q == 3'd5) begin
                     pend_cfg_d   = {shreg_q[4:0], sdi_bit};
                     cfg_update_d = 1'b1;
                  end
               end
               if (sck_fall) begin
                  result_d = {result_q[DATA_W-2:0], 1'b0};
                  sdo_d    = result_q[DATA_W-2];
               end
            end
         end
         default: state_d = StIdle;
      endcase

      if (err_event) begin
         err_d = 1'b1;
      end else if (err_clear) begin
         err_d = 1'b0;
      end else begin
         err_d = err_q;
      end
   end

   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         act_cfg_q    <= DEFAULT_CFG[5:1];
         pend_cfg_q   <= DEFAULT_CFG;
         shreg_q      <= '0;
         rise_cnt_q   <= '0;
         result_q     <= '0;
         sdo_q        <= 1'b0;
         cfg_update_q <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         act_cfg_q    <= act_cfg_d;
         pend_cfg_q   <= pend_cfg_d;
         shreg_q      <= shreg_d;
         rise_cnt_q   <= rise_cnt_d;
         result_q     <= result_d;
         sdo_q        <= sdo_d;
         cfg_update_q <= cfg_update_d;
         err_q        <= err_d;
      end
   end

   assign adc_sdo      = sdo_q;
   assign cfg_word     = pend_cfg_q;
   assign cfg_update   = cfg_update_q;
   assign busy         = (state_q == StConvert);
   assign protocol_err = err_q;

endmodule

// File: tb/tb_ltc2308_responder.sv
// Self-checking bench for ltc2308_responder: drives the controller side of the conduit and
// compares shifted-out codes against an arithmetic model of the converter.
module tb_ltc2308_responder;

   localparam int unsigned CONV_CYCLES = 80;
   localparam int unsigned DATA_W      = 12;
   localparam logic [5:0]  DEFAULT_CFG = 6'b100010;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        convst = 1'b0;
   logic        sck = 1'b0;
   logic        sdi = 1'b0;
   logic        err_clear = 1'b0;
   logic [95:0] chan = '0;
   logic        sdo;
   logic [5:0]  cfg_word;
   logic        cfg_update;
   logic        busy;
   logic        perr;

   int          n_checks = 0;
   int          n_fail = 0;
   logic [5:0]  pend_cfg = DEFAULT_CFG;
   logic [5:0]  act_cfg = DEFAULT_CFG;
   int          upd_count = 0;
   int          run_cur = 0;
   int          run_last = 0;

   ltc2308_responder #(
      .CONV_CYCLES (CONV_CYCLES),
      .DATA_W      (DATA_W),
      .DEFAULT_CFG (DEFAULT_CFG)
   ) dut (
      .clk_clk      (clk),
      .reset_reset  (reset),
      .adc_convst   (convst),
      .adc_sck      (sck),
      .adc_sdi      (sdi),
      .adc_sdo      (sdo),
      .chan_values  (chan),
      .cfg_word     (cfg_word),
      .cfg_update   (cfg_update),
      .busy         (busy),
      .protocol_err (perr),
      .err_clear    (err_clear)
   );

   always #5 clk = ~clk;

   // Observers: count cfg_update pulses and measure the length of the last busy window.
   always @(posedge clk) begin
      if (cfg_update) upd_count <= upd_count + 1;
      if (busy) begin
         run_cur <= run_cur + 1;
      end else if (run_cur != 0) begin
         run_last <= run_cur;
         run_cur  <= 0;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time expired, required completion");
      $fatal(1, "watchdog");
   end

   function automatic int ch_val(input logic [95:0] c, input int k);
      return int'(c[12*k +: 12]);
   endfunction

   // Converter behaviour written from the datasheet rules with integer arithmetic.
   function automatic logic [11:0] model_code(input logic [5:0] cfg, input logic [95:0] c);
      int s, os, a, p, m, d, q, r;
      s  = int'(cfg[3:2]);
      os = int'(cfg[4]);
      if (cfg[5]) begin
         a = ch_val(c, 2*s + os);
         r = cfg[1] ? a : (a + 2048) % 4096;
      end else begin
         p = ch_val(c, 2*s + os);
         m = ch_val(c, 2*s + 1 - os);
         d = p - m;
         if (cfg[1]) begin
            r = (d < 0) ? 0 : d;
         end else begin
            q = (d >= 0) ? d / 2 : -((1 - d) / 2);
            r = (q + 4096) % 4096;
         end
      end
      return 12'(r);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ch(input int k, input logic [11:0] v);
      chan[12*k +: 12] = v;
   endtask

   task automatic start_conv();
      act_cfg = pend_cfg;
      convst  = 1'b1;
      tick();
      tick();
      convst  = 1'b0;
   endtask

   task automatic wait_conv();
      int k;
      k = 0;
      while (!busy && k < 10) begin
         tick();
         k++;
      end
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL busy_start: busy=%b required 1 within 10 cycles", busy);
      end
      k = 0;
      while (busy && k < int'(CONV_CYCLES) + 10) begin
         tick();
         k++;
      end
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL busy_end: busy=%b required 0 within %0d cycles", busy, CONV_CYCLES + 10);
      end
      tick();
      tick();
   endtask

   // One SPI frame: SDI MSB first, SDO sampled before each SCK rise.
   task automatic frame(input logic [5:0] word, input int n, output logic [11:0] bits,
                        output logic tail_bad);
      bits     = '0;
      tail_bad = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (i < 12) bits[11-i] = sdo;
         else if (sdo !== 1'b0) tail_bad = 1'b1;
         sdi = (i < 6) ? word[5-i] : 1'b0;
         sck = 1'b1;
         repeat (4) tick();
         sck = 1'b0;
         repeat (4) tick();
      end
      sdi = 1'b0;
      if (n >= 6) pend_cfg = word;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      pend_cfg = DEFAULT_CFG;
      tick();
      n_checks++;
      if (sdo !== 1'b0) begin n_fail++; $display("FAIL reset_sdo: got %b required 0", sdo); end
      n_checks++;
      if (cfg_word !== DEFAULT_CFG) begin
         n_fail++; $display("FAIL reset_cfg: got %b required %b", cfg_word, DEFAULT_CFG);
      end
      n_checks++;
      if (cfg_update !== 1'b0) begin
         n_fail++; $display("FAIL reset_upd: got %b required 0", cfg_update);
      end
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
      n_checks++;
      if (perr !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b required 0", perr); end
   endtask

   task automatic test_basic();
      logic [11:0] bits;
      logic        tail;
      int          u0;
      chan = {$urandom(), $urandom(), $urandom()};
      set_ch(0, 12'hABC);
      start_conv();
      wait_conv();
      n_checks++;
      if (run_last != int'(CONV_CYCLES)) begin
         n_fail++; $display("FAIL busy_len: got %0d required %0d", run_last, CONV_CYCLES);
      end
      u0 = upd_count;
      frame(6'b000000, 12, bits, tail);
      n_checks++;
      if (bits !== 12'hABC) begin
         n_fail++; $display("FAIL basic_code: got %h required abc", bits);
      end
      n_checks++;
      if (cfg_word !== 6'b000000) begin
         n_fail++; $display("FAIL basic_cfg: got %b required 000000", cfg_word);
      end
      n_checks++;
      if (upd_count - u0 != 1) begin
         n_fail++; $display("FAIL basic_upd: got %0d pulses required 1", upd_count - u0);
      end
      n_checks++;
      if (sdo !== 1'b0) begin n_fail++; $display("FAIL basic_sdo_end: got %b required 0", sdo); end
   endtask

   task automatic test_config_select();
      logic [11:0] bits;
      logic        tail;
      set_ch(1, 12'h123);
      start_conv();
      wait_conv();
      frame(6'b110010, 12, bits, tail);
      n_checks++;
      if (bits !== model_code(6'b000000, chan)) begin
         n_fail++; $display("FAIL cfg_prev_code: got %h required %h", bits,
                            model_code(6'b000000, chan));
      end
      start_conv();
      wait_conv();
      frame(6'b000110, 12, bits, tail);
      n_checks++;
      if (bits !== 12'h123) begin
         n_fail++; $display("FAIL cfg_ch1_code: got %h required 123", bits);
      end
      n_checks++;
      if (cfg_word !== 6'b000110) begin
         n_fail++; $display("FAIL cfg_word_next: got %b required 000110", cfg_word);
      end
   endtask

   task automatic test_differential();
      logic [11:0] bits;
      logic        tail;
      set_ch(2, 12'd100);
      set_ch(3, 12'd300);
      start_conv();
      wait_conv();
      frame(6'b000100, 12, bits, tail);
      n_checks++;
      if (bits !== 12'h000) begin
         n_fail++; $display("FAIL diff_uni_clamp: got %h required 000", bits);
      end
      start_conv();
      wait_conv();
      frame(DEFAULT_CFG, 12, bits, tail);
      n_checks++;
      if (bits !== 12'hF9C) begin
         n_fail++; $display("FAIL diff_bipolar: got %h required f9c", bits);
      end
   endtask

   task automatic test_protocol_err();
      logic [11:0] bits;
      logic        tail;
      chan = {$urandom(), $urandom(), $urandom()};
      start_conv();
      repeat (4) tick();
      sck = 1'b1;
      repeat (4) tick();
      sck = 1'b0;
      repeat (4) tick();
      convst = 1'b1;
      tick();
      tick();
      convst = 1'b0;
      repeat (4) tick();
      n_checks++;
      if (perr !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b required 1", perr); end
      err_clear = 1'b1;
      tick();
      err_clear = 1'b0;
      tick();
      n_checks++;
      if (perr !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %b required 0", perr); end
      // Clear lands in the same cycle the SCK rise is detected.
      sck = 1'b1;
      tick();
      tick();
      err_clear = 1'b1;
      tick();
      err_clear = 1'b0;
      n_checks++;
      if (perr !== 1'b1) begin
         n_fail++; $display("FAIL err_vs_clear: got %b required 1", perr);
      end
      sck = 1'b0;
      repeat (4) tick();
      wait_conv();
      n_checks++;
      if (run_last != int'(CONV_CYCLES)) begin
         n_fail++; $display("FAIL err_busy_len: got %0d required %0d", run_last, CONV_CYCLES);
      end
      frame(pend_cfg, 12, bits, tail);
      n_checks++;
      if (bits !== model_code(act_cfg, chan)) begin
         n_fail++; $display("FAIL err_code: got %h required %h", bits, model_code(act_cfg, chan));
      end
      err_clear = 1'b1;
      tick();
      err_clear = 1'b0;
      tick();
   endtask

   task automatic test_abort_and_overrun();
      logic [11:0] bits;
      logic        tail;
      logic [5:0]  cw;
      int          u0;
      chan = {$urandom(), $urandom(), $urandom()};
      start_conv();
      wait_conv();
      cw = pend_cfg;
      u0 = upd_count;
      frame(6'b101101, 3, bits, tail);
      start_conv();
      n_checks++;
      if (cfg_word !== cw) begin
         n_fail++; $display("FAIL abort_cfg: got %b required %b", cfg_word, cw);
      end
      n_checks++;
      if (upd_count != u0) begin
         n_fail++; $display("FAIL abort_upd: got %0d pulses required 0", upd_count - u0);
      end
      wait_conv();
      frame(pend_cfg, 14, bits, tail);
      n_checks++;
      if (bits !== model_code(act_cfg, chan)) begin
         n_fail++; $display("FAIL abort_next_code: got %h required %h", bits,
                            model_code(act_cfg, chan));
      end
      n_checks++;
      if (tail !== 1'b0) begin n_fail++; $display("FAIL overrun_tail: got %b required 0", tail); end
      n_checks++;
      if (sdo !== 1'b0) begin n_fail++; $display("FAIL overrun_sdo: got %b required 0", sdo); end
   endtask

   task automatic test_random();
      logic [11:0] bits;
      logic        tail;
      logic [5:0]  w;
      for (int it = 0; it < 10; it++) begin
         chan = {$urandom(), $urandom(), $urandom()};
         w    = 6'($urandom_range(0, 63));
         start_conv();
         wait_conv();
         frame(w, 12, bits, tail);
         n_checks++;
         if (bits !== model_code(act_cfg, chan)) begin
            n_fail++; $display("FAIL rand_code[%0d]: cfg %b got %h required %h", it, act_cfg, bits,
                               model_code(act_cfg, chan));
         end
         n_checks++;
         if (cfg_word !== w) begin
            n_fail++; $display("FAIL rand_cfg[%0d]: got %b required %b", it, cfg_word, w);
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [11:0] bits;
      logic        tail;
      chan = {$urandom(), $urandom(), $urandom()};
      start_conv();
      wait_conv();
      frame(6'b011101, 12, bits, tail);
      start_conv();
      wait_conv();
      n_checks++;
      if (cfg_word !== 6'b011101) begin
         n_fail++; $display("FAIL pre_reset_cfg: got %b required 011101", cfg_word);
      end
      for (int i = 0; i < 5; i++) begin
         sck = 1'b1;
         repeat (4) tick();
         sck = 1'b0;
         if (i == 4) reset = 1'b1;
         else repeat (4) tick();
      end
      tick();
      n_checks++;
      if (sdo !== 1'b0) begin n_fail++; $display("FAIL mid_reset_sdo: got %b required 0", sdo); end
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++; $display("FAIL mid_reset_busy: got %b required 0", busy);
      end
      n_checks++;
      if (cfg_word !== DEFAULT_CFG) begin
         n_fail++; $display("FAIL mid_reset_cfg: got %b required %b", cfg_word, DEFAULT_CFG);
      end
      reset = 1'b0;
      pend_cfg = DEFAULT_CFG;
      tick();
      start_conv();
      wait_conv();
      frame(DEFAULT_CFG, 12, bits, tail);
      n_checks++;
      if (bits !== model_code(DEFAULT_CFG, chan)) begin
         n_fail++; $display("FAIL post_reset_code: got %h required %h", bits,
                            model_code(DEFAULT_CFG, chan));
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_config_select();
      test_differential();
      test_protocol_err();
      test_abort_and_overrun();
      test_random();
      test_reset_mid_frame();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
